// File: rtl/settings_bank_marine_radar_pkg.sv
// Shared definitions for the marine-radar settings bank.
//   - Default serial addresses of the bank and of its commit/control register.
//   - Bit positions of the commands in the commit register.
//   - FSM state encoding (SB_IDLE / SB_ARMED).
//   - Helper that resolves one commit-register write into a single command.
package settings_bank_marine_radar_pkg;

    localparam logic [6:0] FR_SETTINGS_BANK_BASE   = 7'd32;
    localparam logic [6:0] FR_SETTINGS_BANK_COMMIT = 7'd31;

    localparam int SB_COMMIT_NOW      = 0;
    localparam int SB_COMMIT_ARM      = 1;
    localparam int SB_COMMIT_DISCARD  = 2;
    localparam int SB_COMMIT_DEFAULTS = 31;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_ARMED = 1'b1
    } sb_state_t;

    typedef struct packed {
        logic defaults;
        logic discard;
        logic now;
        logic arm;
    } sb_cmd_t;

    // At most one field is set. Priority: DEFAULTS > DISCARD > NOW > ARM.
    function automatic sb_cmd_t sb_decode_cmd(input logic wr, input logic [31:0] data);
        sb_cmd_t cmd;
        cmd          = '0;
        cmd.defaults = wr && data[SB_COMMIT_DEFAULTS];
        cmd.discard  = wr && data[SB_COMMIT_DISCARD] && !cmd.defaults;
        cmd.now      = wr && data[SB_COMMIT_NOW] && !cmd.defaults && !cmd.discard;
        cmd.arm      = wr && data[SB_COMMIT_ARM] && !cmd.defaults && !cmd.discard && !cmd.now;
        return cmd;
    endfunction

endpackage

// File: rtl/settings_bank_marine_radar_slot.sv
// One double-buffered setting register.
// Ports:
//   master_clk, reset_n  clock, asynchronous active-low reset
//   wr_en, wr_data       serial write into the shadow copy (marks it dirty)
//   commit               copy shadow to active if dirty
//   load_default         force shadow and active to DEFAULT
//   discard              revert shadow to active
//   active               committed value
//   dirty, dirty_nxt     dirty flag and its next-cycle value
//   changed              one-cycle pulse when active is updated
module settings_bank_marine_radar_slot #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             master_clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit,
    input  logic             load_default,
    input  logic             discard,
    output logic [WIDTH-1:0] active,
    output logic             dirty,
    output logic             dirty_nxt,
    output logic             changed
);

    logic [WIDTH-1:0] shadow;

    // A write landing in the same cycle as a commit re-dirties the slot.
    always_comb begin
        dirty_nxt = dirty;
        if (load_default || discard) begin
            dirty_nxt = 1'b0;
        end else begin
            if (commit) dirty_nxt = 1'b0;
            if (wr_en)  dirty_nxt = 1'b1;
        end
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            active  <= DEFAULT;
            shadow  <= DEFAULT;
            dirty   <= 1'b0;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            dirty   <= dirty_nxt;
            if (load_default) begin
                active  <= DEFAULT;
                shadow  <= DEFAULT;
                changed <= (active != DEFAULT);
            end else if (discard) begin
                shadow <= active;
            end else begin
                // Commit takes the pre-write shadow value.
                if (commit && dirty) begin
                    active  <= shadow;
                    changed <= 1'b1;
                end
                if (wr_en) shadow <= wr_data;
            end
        end
    end

endmodule

// File: rtl/settings_bank_marine_radar.sv
// Bank of N_REGS double-buffered radar setting registers on the serial bus.
// Writes to BASE_ADDR+i land in shadow copies; a write to COMMIT_ADDR commits
// immediately (NOW), arms a commit for the next sync_pulse (ARM), reverts the
// shadows (DISCARD) or restores DEFAULTS, so settings only change between sweeps.
// Ports:
//   master_clk, reset_n                    clock, asynchronous active-low reset
//   serial_addr/data/strobe                serial write bus
//   sync_pulse                             sweep boundary, lands an armed commit
//   settings                               active values, reg i at [i*WIDTH +: WIDTH]
//   changed                                per-register one-cycle update pulse
//   pending                                some shadow register is uncommitted
//   armed                                  commit waiting for sync_pulse
//   rb_addr, rb_data                       readback, one-cycle latency
//                                          (only with SETTINGS_BANK_READBACK_EN)
//
// state    | meaning
// SB_IDLE  | no commit scheduled
// SB_ARMED | commit fires on the next sync_pulse
module settings_bank_marine_radar
    import settings_bank_marine_radar_pkg::*;
#(
    parameter logic [6:0]              BASE_ADDR   = FR_SETTINGS_BANK_BASE,
    parameter int                      N_REGS      = 16,
    parameter int                      WIDTH       = 32,
    parameter logic [6:0]              COMMIT_ADDR = FR_SETTINGS_BANK_COMMIT,
    parameter logic [N_REGS*WIDTH-1:0] DEFAULTS    = '0
) (
    input  logic                      master_clk,
    input  logic                      reset_n,
    input  logic [6:0]                serial_addr,
    input  logic [31:0]               serial_data,
    input  logic                      serial_strobe,
    input  logic                      sync_pulse,
`ifdef SETTINGS_BANK_READBACK_EN
    input  logic [6:0]                rb_addr,
    output logic [31:0]               rb_data,
`endif
    output logic [N_REGS*WIDTH-1:0]   settings,
    output logic [N_REGS-1:0]         changed,
    output logic                      pending,
    output logic                      armed
);

    generate
        if (N_REGS < 1 || N_REGS > 32 || WIDTH < 1 || WIDTH > 32) begin : g_bad_size
            $fatal(1, "settings_bank_marine_radar: N_REGS and WIDTH must be 1..32");
        end
        if (int'(COMMIT_ADDR) >= int'(BASE_ADDR) &&
            int'(COMMIT_ADDR) < int'(BASE_ADDR) + N_REGS) begin : g_bad_commit
            $fatal(1, "settings_bank_marine_radar: COMMIT_ADDR overlaps the register window");
        end
        if (int'(BASE_ADDR) + N_REGS > 128) begin : g_bad_range
            $fatal(1, "settings_bank_marine_radar: register window exceeds 7-bit address space");
        end
    endgenerate

    sb_state_t          state;
    sb_cmd_t            cmd;
    logic               sync_commit;
    logic               commit;
    logic [N_REGS-1:0]  dirty;
    logic [N_REGS-1:0]  dirty_nxt;

    assign cmd = sb_decode_cmd(serial_strobe && (serial_addr == COMMIT_ADDR), serial_data);

    // An ARM in the same cycle does not block a sync commit that is already armed.
    assign sync_commit = (state == SB_ARMED) && sync_pulse &&
                         !cmd.defaults && !cmd.discard && !cmd.now;
    assign commit      = cmd.now || sync_commit;

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SB_IDLE;
        end else begin
            case (state)
                SB_IDLE:  if (cmd.arm) state <= SB_ARMED;
                SB_ARMED: if (cmd.defaults || cmd.discard || commit) state <= SB_IDLE;
                default:  state <= SB_IDLE;
            endcase
        end
    end

    assign armed = (state == SB_ARMED);

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) pending <= 1'b0;
        else          pending <= |dirty_nxt;
    end

    for (genvar i = 0; i < N_REGS; i++) begin : g_slot
        localparam logic [6:0] SLOT_ADDR = 7'(int'(BASE_ADDR) + i);
        settings_bank_marine_radar_slot #(
            .WIDTH   (WIDTH),
            .DEFAULT (DEFAULTS[i*WIDTH +: WIDTH])
        ) u_slot (
            .master_clk   (master_clk),
            .reset_n      (reset_n),
            .wr_en        (serial_strobe && (serial_addr == SLOT_ADDR)),
            .wr_data      (serial_data[WIDTH-1:0]),
            .commit       (commit),
            .load_default (cmd.defaults),
            .discard      (cmd.discard),
            .active       (settings[i*WIDTH +: WIDTH]),
            .dirty        (dirty[i]),
            .dirty_nxt    (dirty_nxt[i]),
            .changed      (changed[i])
        );
    end

`ifdef SETTINGS_BANK_READBACK_EN
    logic [31:0] dirty_ext;
    logic [31:0] rb_next;

    assign dirty_ext = 32'(dirty);

    always_comb begin
        rb_next = '0;
        if (rb_addr == COMMIT_ADDR) begin
            rb_next = {armed, pending, 22'b0, dirty_ext[7:0]};
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (rb_addr == 7'(int'(BASE_ADDR) + i)) rb_next = 32'(settings[i*WIDTH +: WIDTH]);
            end
        end
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) rb_data <= '0;
        else          rb_data <= rb_next;
    end
`endif

endmodule

// File: tb/tb_settings_bank_marine_radar.sv
module tb_settings_bank_marine_radar;

    localparam int         N     = 16;
    localparam int         W     = 32;
    localparam logic [6:0] BASE  = 7'd32;
    localparam logic [6:0] CADDR = 7'd31;
    localparam logic [N*W-1:0] DEFS = ({{(N*W-32){1'b0}}, 32'h5}    << (3*W)) |
                                      ({{(N*W-32){1'b0}}, 32'hA5A5} << (2*W)) |
                                      ({{(N*W-32){1'b0}}, 32'h77}   << (5*W));

    logic             master_clk;
    logic             reset_n;
    logic [6:0]       serial_addr;
    logic [31:0]      serial_data;
    logic             serial_strobe;
    logic             sync_pulse;
    logic [N*W-1:0]   settings;
    logic [N-1:0]     changed;
    logic             pending;
    logic             armed;
`ifdef SETTINGS_BANK_READBACK_EN
    logic [6:0]       rb_addr;
    logic [31:0]      rb_data;
`endif

    settings_bank_marine_radar #(
        .BASE_ADDR   (BASE),
        .N_REGS      (N),
        .WIDTH       (W),
        .COMMIT_ADDR (CADDR),
        .DEFAULTS    (DEFS)
    ) dut (
        .master_clk    (master_clk),
        .reset_n       (reset_n),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .sync_pulse    (sync_pulse),
`ifdef SETTINGS_BANK_READBACK_EN
        .rb_addr       (rb_addr),
        .rb_data       (rb_data),
`endif
        .settings      (settings),
        .changed       (changed),
        .pending       (pending),
        .armed         (armed)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register arrays updated transaction by transaction.
    logic [W-1:0] m_act [N];
    logic [W-1:0] m_sh  [N];
    logic [N-1:0] m_dirty;
    logic [N-1:0] m_chg;
    logic         m_armed;

    function automatic logic [W-1:0] def_of(input int i);
        return DEFS[i*W +: W];
    endfunction

    function automatic logic [W-1:0] reg_of(input int i);
        return settings[i*W +: W];
    endfunction

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = def_of(i);
            m_sh[i]  = def_of(i);
        end
        m_dirty = '0;
        m_chg   = '0;
        m_armed = 1'b0;
    endtask

    task automatic model_commit();
        for (int i = 0; i < N; i++) begin
            if (m_dirty[i]) begin
                m_act[i]   = m_sh[i];
                m_chg[i]   = 1'b1;
                m_dirty[i] = 1'b0;
            end
        end
    endtask

    task automatic model_step(input logic stb, input logic [6:0] a, input logic [31:0] d, input logic sy);
        logic cw;
        cw    = stb && (a == CADDR);
        m_chg = '0;
        if (cw && d[31]) begin
            for (int i = 0; i < N; i++) begin
                m_chg[i] = (m_act[i] != def_of(i));
                m_act[i] = def_of(i);
                m_sh[i]  = def_of(i);
            end
            m_dirty = '0;
            m_armed = 1'b0;
        end else if (cw && d[2]) begin
            for (int i = 0; i < N; i++) m_sh[i] = m_act[i];
            m_dirty = '0;
            m_armed = 1'b0;
        end else if (cw && d[0]) begin
            model_commit();
            m_armed = 1'b0;
        end else begin
            if (m_armed && sy) begin
                model_commit();
                m_armed = 1'b0;
            end else if (cw && d[1]) begin
                m_armed = 1'b1;
            end
            if (stb && a >= BASE && int'(a) < int'(BASE) + N) begin
                m_sh[int'(a) - int'(BASE)]    = d[W-1:0];
                m_dirty[int'(a) - int'(BASE)] = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        logic [N*W-1:0] flat;
        for (int i = 0; i < N; i++) flat[i*W +: W] = m_act[i];
        check("settings", settings, flat);
        check("changed", N*W'(changed), N*W'(m_chg));
        check("pending", N*W'(pending), N*W'(|m_dirty));
        check("armed", N*W'(armed), N*W'(m_armed));
    endtask

    // One bus cycle: drive, clock, advance model, compare #1 after the edge.
    task automatic cycle(input logic stb, input logic [6:0] a, input logic [31:0] d, input logic sy);
        serial_strobe = stb;
        serial_addr   = a;
        serial_data   = d;
        sync_pulse    = sy;
        @(posedge master_clk);
        model_step(stb, a, d, sy);
        #1;
        compare_model();
        serial_strobe = 1'b0;
        sync_pulse    = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        model_reset();
        compare_model();
        @(posedge master_clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        stb;
        logic [6:0]  a;
        logic [31:0] d;
        logic        sy;
        int          ridx;
        logic [31:0] rval;
        logic [15:0] chg;
        logic        pend;
        logic        arm;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Commit NOW (test 2) and DISCARD followed by NOW (test 5).
        vecs[0] = '{1'b1, BASE + 7'd2, 32'h1234, 1'b0, 2, 32'hA5A5, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, CADDR,       32'h1,    1'b0, 2, 32'h1234, 16'h0004, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 7'd0,        32'h0,    1'b0, 2, 32'h1234, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, BASE + 7'd4, 32'hFF,   1'b0, 4, 32'h0,    16'h0000, 1'b1, 1'b0};
        vecs[4] = '{1'b1, CADDR,       32'h4,    1'b0, 4, 32'h0,    16'h0000, 1'b0, 1'b0};
        vecs[5] = '{1'b1, CADDR,       32'h1,    1'b0, 4, 32'h0,    16'h0000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, BASE + 7'd16,32'hDEAD, 1'b0, 4, 32'h0,    16'h0000, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 7'd0,        32'h0,    1'b1, 2, 32'h1234, 16'h0000, 1'b0, 1'b0};

        reset_n       = 1'b0;
        serial_strobe = 1'b0;
        serial_addr   = '0;
        serial_data   = '0;
        sync_pulse    = 1'b0;
`ifdef SETTINGS_BANK_READBACK_EN
        rb_addr       = '0;
`endif
        @(posedge master_clk);
        #1;
        do_reset();

        // Test 1: reset values.
        check("rst_reg3", N*W'(reg_of(3)), N*W'(32'h5));
        check("rst_changed", N*W'(changed), '0);
        check("rst_pending", N*W'(pending), '0);
        check("rst_armed", N*W'(armed), '0);

        // Tests 2 and 5, table driven.
        for (int k = 0; k < 8; k++) begin
            cycle(vecs[k].stb, vecs[k].a, vecs[k].d, vecs[k].sy);
            check($sformatf("vec%0d_reg", k), N*W'(reg_of(vecs[k].ridx)), N*W'(vecs[k].rval));
            check($sformatf("vec%0d_changed", k), N*W'(changed), N*W'(vecs[k].chg));
            check($sformatf("vec%0d_pending", k), N*W'(pending), N*W'(vecs[k].pend));
            check($sformatf("vec%0d_armed", k), N*W'(armed), N*W'(vecs[k].arm));
        end

        // Test 3: armed commit waits for sync_pulse.
        cycle(1'b1, BASE, 32'h7, 1'b0);
        cycle(1'b1, CADDR, 32'h2, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1'b0, 7'd0, 32'h0, 1'b0);
        check("arm_wait_reg0", N*W'(reg_of(0)), '0);
        check("arm_wait_armed", N*W'(armed), N*W'(1'b1));
        cycle(1'b1, CADDR, 32'h2, 1'b0);
        check("arm_twice_armed", N*W'(armed), N*W'(1'b1));
        cycle(1'b0, 7'd0, 32'h0, 1'b1);
        check("sync_reg0", N*W'(reg_of(0)), N*W'(32'h7));
        check("sync_changed", N*W'(changed), N*W'(16'h0001));
        check("sync_armed", N*W'(armed), '0);
        cycle(1'b0, 7'd0, 32'h0, 1'b0);
        check("sync_changed_gone", N*W'(changed), '0);
        cycle(1'b0, 7'd0, 32'h0, 1'b1);
        check("idle_sync_changed", N*W'(changed), '0);

        // Test 4: write coinciding with the sync commit.
        cycle(1'b1, BASE + 7'd1, 32'd9, 1'b0);
        cycle(1'b1, CADDR, 32'h2, 1'b0);
        cycle(1'b1, BASE + 7'd1, 32'd11, 1'b1);
        check("coinc_reg1", N*W'(reg_of(1)), N*W'(32'd9));
        check("coinc_changed", N*W'(changed), N*W'(16'h0002));
        check("coinc_pending", N*W'(pending), N*W'(1'b1));
        check("coinc_armed", N*W'(armed), '0);
        cycle(1'b1, CADDR, 32'h1, 1'b0);
        check("coinc_now_reg1", N*W'(reg_of(1)), N*W'(32'd11));
        check("coinc_now_pending", N*W'(pending), '0);

        // Reset while armed drops the commit.
        cycle(1'b1, BASE + 7'd6, 32'h3, 1'b0);
        cycle(1'b1, CADDR, 32'h2, 1'b0);
        do_reset();
        cycle(1'b0, 7'd0, 32'h0, 1'b1);
        check("rst_lost_reg6", N*W'(reg_of(6)), '0);
        check("rst_lost_changed", N*W'(changed), '0);

        // Test 6: DEFAULTS restores modified registers.
        cycle(1'b1, BASE + 7'd2, 32'h1, 1'b0);
        cycle(1'b1, BASE + 7'd5, 32'h2, 1'b0);
        cycle(1'b1, CADDR, 32'h1, 1'b0);
        check("mod_reg5", N*W'(reg_of(5)), N*W'(32'h2));
        cycle(1'b1, BASE + 7'd7, 32'h9, 1'b0);
        cycle(1'b1, CADDR, 32'h8000_0003, 1'b0);
        check("dflt_changed", N*W'(changed), N*W'(16'h0024));
        check("dflt_reg2", N*W'(reg_of(2)), N*W'(32'hA5A5));
        check("dflt_reg5", N*W'(reg_of(5)), N*W'(32'h77));
        check("dflt_pending", N*W'(pending), '0);
`ifdef SETTINGS_BANK_READBACK_EN
        rb_addr = BASE + 7'd2;
        cycle(1'b0, 7'd0, 32'h0, 1'b0);
        check("rb_reg2", N*W'(rb_data), N*W'(32'hA5A5));
        cycle(1'b1, BASE + 7'd1, 32'h1, 1'b0);
        rb_addr = CADDR;
        cycle(1'b0, 7'd0, 32'h0, 1'b0);
        check("rb_commit", N*W'(rb_data), N*W'(32'h4000_0002));
        rb_addr = 7'd100;
        cycle(1'b0, 7'd0, 32'h0, 1'b0);
        check("rb_other", N*W'(rb_data), '0);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic [6:0]  a;
            logic [31:0] d;
            int          r;
            r = int'($urandom_range(9));
            d = $urandom;
            if (r < 2) begin
                a = CADDR;
                d = (d & 32'h7FFF_FFF8) | 32'($urandom_range(7));
                if ($urandom_range(15) == 0) d[31] = 1'b1;
            end else if (r < 8) begin
                a = BASE + 7'($urandom_range(N - 1));
            end else if (r == 8) begin
                a = 7'($urandom_range(127));
            end else begin
                a = BASE + 7'(N);
            end
            cycle($urandom_range(3) != 0, a, d, $urandom_range(5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
